// File: rtl/output_checker_pkg.sv
// Shared state encoding for the output_checker monitor.
package output_checker_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

endpackage

// File: rtl/output_checker_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_bar,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      cnt_q <= {W{1'b0}};
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/output_checker.sv
// Watches CPU output strobes, compares them with an arithmetic sequence and
// latches a PASS/FAIL verdict after a fixed number of RUN cycles.
module output_checker
  import output_checker_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int CNT_W          = 16,
  parameter int EXPECT_OUTPUTS = 19,
  parameter int MAX_CYCLES     = 1000,
  parameter int START          = 0,
  parameter int STEP           = 1,
  parameter int STOP_ON_ERROR  = 0
) (
  input  logic               clk,
  input  logic               reset_bar,
  input  logic               en,
  input  logic               strobe,
  input  logic [WIDTH-1:0]   bus,
  output logic [STATE_W-1:0] state,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   cycle,
  output logic [CNT_W-1:0]   outputs,
  output logic [CNT_W-1:0]   errors,
  output logic [CNT_W-1:0]   first_bad_idx,
  output logic [WIDTH-1:0]   first_bad_val
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] EXP_N   = CNT_W'(EXPECT_OUTPUTS);
  localparam logic [CNT_W-1:0] MAX_N   = CNT_W'(MAX_CYCLES);
  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
  localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);

  state_e           state_q;
  logic             done_q;
  logic             pass_q;
  logic [WIDTH-1:0] exp_q;
  logic [CNT_W-1:0] first_bad_idx_q;
  logic [WIDTH-1:0] first_bad_val_q;

  logic             running;
  logic             accept;
  logic             excess;
  logic             err_hit;
  logic             stop_now;
  logic             last_cycle;
  logic [CNT_W-1:0] cycle_d;
  logic [CNT_W-1:0] outputs_d;
  logic [CNT_W-1:0] errors_d;

  // Counter next values are mirrored here so the verdict sees this edge's update.
  always_comb begin
    running    = (state_q == ST_RUN);
    accept     = running & strobe;
    excess     = (outputs >= EXP_N);
    err_hit    = accept & (excess | (bus != exp_q));
    stop_now   = err_hit & (STOP_ON_ERROR != 0);
    cycle_d    = (running && (cycle != CNT_MAX)) ? cycle + CNT_W'(1) : cycle;
    outputs_d  = (accept && (outputs != CNT_MAX)) ? outputs + CNT_W'(1) : outputs;
    errors_d   = (err_hit && (errors != CNT_MAX)) ? errors + CNT_W'(1) : errors;
    last_cycle = running & (cycle_d == MAX_N);
  end

  sat_counter #(.W(CNT_W)) u_cycle (
    .clk       (clk),
    .reset_bar (reset_bar),
    .inc       (running),
    .q         (cycle)
  );

  sat_counter #(.W(CNT_W)) u_outputs (
    .clk       (clk),
    .reset_bar (reset_bar),
    .inc       (accept),
    .q         (outputs)
  );

  sat_counter #(.W(CNT_W)) u_errors (
    .clk       (clk),
    .reset_bar (reset_bar),
    .inc       (err_hit),
    .q         (errors)
  );

  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      state_q         <= ST_IDLE;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      exp_q           <= START_V;
      first_bad_idx_q <= CNT_ZERO;
      first_bad_val_q <= {WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (accept && !excess) begin
            exp_q <= exp_q + STEP_V;
          end else begin
            exp_q <= exp_q;
          end
          if (err_hit && (errors == CNT_ZERO)) begin
            first_bad_idx_q <= outputs;
            first_bad_val_q <= bus;
          end else begin
            first_bad_idx_q <= first_bad_idx_q;
            first_bad_val_q <= first_bad_val_q;
          end
          // An error on the final cycle is already folded into errors_d.
          if (stop_now) begin
            state_q <= ST_FAIL;
            done_q  <= 1'b1;
          end else if (last_cycle) begin
            done_q <= 1'b1;
            if ((errors_d == CNT_ZERO) && (outputs_d == EXP_N)) begin
              state_q <= ST_PASS;
              pass_q  <= 1'b1;
            end else begin
              state_q <= ST_FAIL;
            end
          end else begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign state         = state_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign first_bad_idx = first_bad_idx_q;
  assign first_bad_val = first_bad_val_q;

endmodule

// File: tb/tb_output_checker.sv
// Scoreboard bench: two checker configurations share one stimulus stream;
// expected verdicts come from a strobe-list model and are popped when done rises.
module tb_output_checker;

  localparam int MAXC_A = 1000;

  typedef struct {
    int st;
    int cyc;
    int outs;
    int errs;
    int fbi;
    int fbv;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_bar, en, strobe;
  logic [15:0] bus;

  logic [1:0]  st_a, st_b;
  logic        done_a, pass_a, done_b, pass_b;
  logic [15:0] cyc_a, outs_a, errs_a, fbi_a, fbv_a;
  logic [15:0] cyc_b, outs_b, errs_b, fbi_b;
  logic [3:0]  fbv_b;

  int checks = 0;
  int failures = 0;

  bit          stb [0:MAXC_A-1];
  logic [15:0] val [0:MAXC_A-1];
  int          pos [0:31];
  res_t        q_a[$];
  res_t        q_b[$];

  output_checker dut_a (
    .clk(clk), .reset_bar(reset_bar), .en(en), .strobe(strobe), .bus(bus),
    .state(st_a), .done(done_a), .pass(pass_a), .cycle(cyc_a), .outputs(outs_a),
    .errors(errs_a), .first_bad_idx(fbi_a), .first_bad_val(fbv_a)
  );

  output_checker #(
    .WIDTH(4), .CNT_W(16), .EXPECT_OUTPUTS(4), .MAX_CYCLES(8),
    .START(14), .STEP(1), .STOP_ON_ERROR(1)
  ) dut_b (
    .clk(clk), .reset_bar(reset_bar), .en(en), .strobe(strobe), .bus(bus[3:0]),
    .state(st_b), .done(done_b), .pass(pass_b), .cycle(cyc_b), .outputs(outs_b),
    .errors(errs_b), .first_bad_idx(fbi_b), .first_bad_val(fbv_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Walk the strobe list in order: k-th accepted strobe should equal start+k*step.
  function automatic res_t model(input int w, input int start, input int step,
                                 input int expn, input int maxc, input bit stop);
    res_t r;
    int mask;
    int outs;
    int errs;
    bit bad;
    mask = (1 << w) - 1;
    outs = 0;
    errs = 0;
    r.fbi = 0;
    r.fbv = 0;
    r.cyc = maxc;
    for (int k = 0; k < maxc; k++) begin
      if (stb[k]) begin
        bad = (outs >= expn) || ((int'(val[k]) & mask) != ((start + outs * step) & mask));
        if (bad) begin
          if (errs == 0) begin
            r.fbi = outs;
            r.fbv = int'(val[k]) & mask;
          end
          errs++;
        end
        outs++;
        if (bad && stop) begin
          r.cyc = k + 1;
          r.outs = outs;
          r.errs = errs;
          r.st = 3;
          return r;
        end
      end
    end
    r.outs = outs;
    r.errs = errs;
    r.st = (errs == 0 && outs == expn) ? 2 : 3;
    return r;
  endfunction

  task automatic chk_res(input string t, input res_t e, input int st, input int dn,
                         input int ps, input int cy, input int ou, input int er,
                         input int fi, input int fv);
    chk({t, "_state"}, st, e.st);
    chk({t, "_done"}, dn, 1);
    chk({t, "_pass"}, ps, (e.st == 2) ? 1 : 0);
    chk({t, "_cycle"}, cy, e.cyc);
    chk({t, "_outputs"}, ou, e.outs);
    chk({t, "_errors"}, er, e.errs);
    if (e.errs > 0) begin
      chk({t, "_first_bad_idx"}, fi, e.fbi);
      chk({t, "_first_bad_val"}, fv, e.fbv);
    end
  endtask

  // Monitor for the default configuration.
  initial begin
    res_t cur;
    bit prev = 1'b0;
    bit have = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (done_a === 1'b1) begin
        if (!prev) begin
          if (q_a.size() == 0) begin
            checks++;
            failures++;
            have = 1'b0;
            $display("FAIL a_unexpected_done actual=1 required=0");
          end else begin
            cur = q_a.pop_front();
            have = 1'b1;
          end
        end
        if (have) chk_res("a", cur, st_a, done_a, pass_a, cyc_a, outs_a, errs_a, fbi_a, fbv_a);
      end
      prev = (done_a === 1'b1);
    end
  end

  // Monitor for the narrow, stop-on-error configuration.
  initial begin
    res_t cur;
    bit prev = 1'b0;
    bit have = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (done_b === 1'b1) begin
        if (!prev) begin
          if (q_b.size() == 0) begin
            checks++;
            failures++;
            have = 1'b0;
            $display("FAIL b_unexpected_done actual=1 required=0");
          end else begin
            cur = q_b.pop_front();
            have = 1'b1;
          end
        end
        if (have) chk_res("b", cur, st_b, done_b, pass_b, cyc_b, outs_b, errs_b, fbi_b, fbv_b);
      end
      prev = (done_b === 1'b1);
    end
  end

  task automatic chk_idle(input string t);
    chk({t, "_a_state"}, st_a, 0);
    chk({t, "_a_done"}, done_a, 0);
    chk({t, "_a_pass"}, pass_a, 0);
    chk({t, "_a_cycle"}, cyc_a, 0);
    chk({t, "_a_outputs"}, outs_a, 0);
    chk({t, "_a_errors"}, errs_a, 0);
    chk({t, "_a_first_bad_idx"}, fbi_a, 0);
    chk({t, "_a_first_bad_val"}, fbv_a, 0);
    chk({t, "_b_state"}, st_b, 0);
    chk({t, "_b_cycle"}, cyc_b, 0);
    chk({t, "_b_outputs"}, outs_b, 0);
    chk({t, "_b_errors"}, errs_b, 0);
  endtask

  task automatic clear_stim();
    for (int k = 0; k < MAXC_A; k++) begin
      stb[k] = 1'b0;
      val[k] = 16'($urandom);
    end
  endtask

  // n correct strobes, one per gap-wide slot at a random offset.
  task automatic spread(input int n, input int gap);
    clear_stim();
    for (int i = 0; i < n; i++) begin
      pos[i] = i * gap + $urandom_range(0, gap - 1);
      stb[pos[i]] = 1'b1;
      val[pos[i]] = 16'(i);
    end
  endtask

  task automatic fill_random(input bit narrow_first);
    int c;
    int dens;
    c = 0;
    clear_stim();
    for (int k = 0; k < MAXC_A; k++) begin
      dens = (k < 8) ? 50 : 2;
      if ($urandom_range(0, 99) < dens) begin
        stb[k] = 1'b1;
        val[k] = (narrow_first && k < 8) ? 16'((14 + c) & 15) : 16'(c);
        if ($urandom_range(0, 14) == 0) val[k] = val[k] ^ 16'(1 << $urandom_range(0, 3));
        c++;
      end
    end
  endtask

  task automatic do_run(input int cut);
    res_t ea;
    res_t eb;
    ea = model(16, 0, 1, 19, MAXC_A, 1'b0);
    eb = model(4, 14, 1, 4, 8, 1'b1);
    if (cut >= MAXC_A) q_a.push_back(ea);
    q_b.push_back(eb);
    repeat (3) begin
      @(negedge clk);
      en = 1'b0;
      strobe = 1'($urandom);
      bus = 16'($urandom);
    end
    @(negedge clk);
    en = 1'b1;
    strobe = 1'($urandom);
    bus = 16'($urandom);
    for (int k = 0; k < cut; k++) begin
      @(negedge clk);
      en = 1'($urandom);
      strobe = stb[k];
      bus = val[k];
    end
    @(negedge clk);
    chk("b_done_by_deadline", done_b, 1);
    if (cut >= MAXC_A) begin
      chk("a_done_by_deadline", done_a, 1);
      repeat (4) begin
        en = 1'b1;
        strobe = 1'b1;
        bus = 16'($urandom);
        @(negedge clk);
      end
    end else begin
      chk("a_still_running", st_a, 1);
    end
    reset_bar = 1'b0;
    en = 1'b1;
    strobe = 1'b1;
    @(negedge clk);
    reset_bar = 1'b1;
    en = 1'b0;
    strobe = 1'b0;
    chk_idle("after_reset");
    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
  endtask

  initial begin
    reset_bar = 1'b0;
    en = 1'b0;
    strobe = 1'b0;
    bus = 16'd0;
    repeat (3) @(negedge clk);
    reset_bar = 1'b1;
    chk_idle("init");

    spread(19, 50);
    do_run(MAXC_A);

    spread(19, 50);
    val[pos[5]] = 16'd99;
    do_run(MAXC_A);

    spread(18, 50);
    do_run(MAXC_A);

    spread(20, 49);
    do_run(MAXC_A);

    spread(19, 50);
    stb[pos[18]] = 1'b0;
    stb[MAXC_A-1] = 1'b1;
    val[MAXC_A-1] = 16'd18;
    do_run(MAXC_A);

    // Wrapping sequence for the narrow instance, last strobe on its final cycle.
    clear_stim();
    stb[0] = 1'b1; val[0] = 16'd14;
    stb[2] = 1'b1; val[2] = 16'd15;
    stb[4] = 1'b1; val[4] = 16'd0;
    stb[7] = 1'b1; val[7] = 16'd1;
    do_run(MAXC_A);

    // Bad value at index 2 stops the narrow instance early.
    clear_stim();
    stb[0] = 1'b1; val[0] = 16'd14;
    stb[1] = 1'b1; val[1] = 16'd15;
    stb[4] = 1'b1; val[4] = 16'd5;
    stb[6] = 1'b1; val[6] = 16'd1;
    do_run(MAXC_A);

    for (int r = 0; r < 6; r++) begin
      fill_random(r[0]);
      do_run(MAXC_A);
    end

    spread(19, 50);
    do_run(300);

    spread(19, 50);
    do_run(MAXC_A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
